// File: rtl/stopwatch_ctrl.sv
`timescale 1ns/1ps
// Front-panel sequencer for the MM:SS stopwatch: button sync/debounce,
// run/pause/lap FSM, per-second count enable and display freeze/latch controls.
//
// state | meaning
// IDLE  | stopped at 00:00, waiting for start
// RUN   | counting, display shows live digits
// PAUSE | counting held, partial second preserved
// LAP   | counting, display frozen on latched lap value
module stopwatch_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start_stop,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic       count_en,
    output logic       count_clr,
    output logic       lap_latch,
    output logic       disp_freeze,
    output logic       running,
    output logic [1:0] state
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    // bit 0 = start_stop, bit 1 = lap, bit 2 = clear
    logic [2:0]    btn_raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb;
    logic [2:0]    deb_d;
    logic [DW-1:0] deb_cnt [3];
    logic [2:0]    press;

    state_t        st;
    logic [PW-1:0] presc;

    assign btn_raw = {btn_clear, btn_lap, btn_start_stop};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_MAX) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Only rising debounced edges are events; releases are silent.
    assign press = deb & ~deb_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= IDLE;
            presc     <= '0;
            count_clr <= 1'b0;
            lap_latch <= 1'b0;
        end else begin
            count_clr <= 1'b0;
            lap_latch <= 1'b0;
            if (running) presc <= (presc == PRESC_TOP) ? '0 : presc + PW'(1);
            case (st)
                IDLE: begin
                    presc <= '0;
                    if (press[2])      count_clr <= 1'b1;
                    else if (press[0]) st <= RUN;
                end
                RUN: begin
                    if (press[0]) begin
                        st <= PAUSE;
                    end else if (press[1]) begin
                        st        <= LAP;
                        lap_latch <= 1'b1;
                    end
                end
                LAP: begin
                    if (press[0])      st <= PAUSE;
                    else if (press[1]) st <= RUN;
                end
                PAUSE: begin
                    if (press[2]) begin
                        st        <= IDLE;
                        count_clr <= 1'b1;
                        presc     <= '0;
                    end else if (press[0]) begin
                        st <= RUN;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign state       = st;
    assign running     = (st == RUN) || (st == LAP);
    assign disp_freeze = (st == LAP);
    assign count_en    = running && (presc == PRESC_TOP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
`timescale 1ns/1ps
// Directed bench for stopwatch_ctrl with TICK_DIV=10, DEB_CYCLES=4.
// Output vector layout: {state[1:0], count_en, count_clr, lap_latch, disp_freeze, running}.
module tb_stopwatch_ctrl;

    localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSE = 2'b10, S_LAP = 2'b11;
    localparam logic [6:0] O_IDLE   = 7'b00_00000;
    localparam logic [6:0] O_RUN    = 7'b01_00001;
    localparam logic [6:0] O_RUN_EN = 7'b01_10001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_start_stop = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0;
    logic count_en, count_clr, lap_latch, disp_freeze, running;
    logic [1:0] state;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       ss;
        logic       lap;
        logic       clr;
        int         n;
        logic [6:0] exp;
    } vec_t;
    vec_t vt [7];

    stopwatch_ctrl #(.TICK_DIV(10), .DEB_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .btn_start_stop(btn_start_stop), .btn_lap(btn_lap), .btn_clear(btn_clear),
        .count_en(count_en), .count_clr(count_clr), .lap_latch(lap_latch),
        .disp_freeze(disp_freeze), .running(running), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [6:0] outs();
        return {state, count_en, count_clr, lap_latch, disp_freeze, running};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!count_en && n < 25);
        chk(name, 32'(count_en), 32'd1);
    endtask

    initial begin
        vt[0] = '{1'b1, 1'b0, 1'b0, 7, O_IDLE};
        vt[1] = '{1'b1, 1'b0, 1'b0, 9, O_RUN};
        vt[2] = '{1'b1, 1'b0, 1'b0, 1, O_RUN_EN};
        vt[3] = '{1'b1, 1'b0, 1'b0, 3, O_RUN};
        vt[4] = '{1'b0, 1'b0, 1'b0, 6, O_RUN};
        vt[5] = '{1'b0, 1'b0, 1'b0, 1, O_RUN_EN};
        vt[6] = '{1'b0, 1'b0, 1'b0, 2, O_RUN};

        #23;
        chk("reset_outs", 32'(outs()), 32'(O_IDLE));
        @(posedge clk);
        #3 reset = 1'b0;
        #1;

        // start press: event 7 cycles after raw edge, RUN one cycle later, count_en every 10
        for (int i = 0; i < 7; i++) begin
            btn_start_stop = vt[i].ss;
            btn_lap        = vt[i].lap;
            btn_clear      = vt[i].clr;
            for (int j = 0; j < vt[i].n; j++) begin
                tick();
                chk($sformatf("vec%0d.%0d", i, j), 32'(outs()), 32'(vt[i].exp));
            end
        end

        // lap glitches then a real press
        wait_en("sync_lap");
        for (int t = 1; t <= 40; t++) begin
            logic [6:0] e;
            btn_lap = (t == 1) || (t >= 7 && t <= 8) || (t >= 14 && t <= 16) || (t >= 22 && t <= 27);
            tick();
            e = {(t >= 29) ? S_LAP : S_RUN, (t % 10 == 0), 1'b0, (t == 29), (t >= 29), 1'b1};
            chk($sformatf("lap_glitch.%0d", t), 32'(outs()), 32'(e));
        end
        for (int t = 1; t <= 20; t++) begin
            btn_lap = (t <= 10);
            tick();
            if (t == 7) chk("lap2_before", 32'(state), 32'(S_LAP));
            if (t == 8) chk("lap2_exit", 32'({state, lap_latch, disp_freeze}), 32'({S_RUN, 2'b00}));
        end

        // pause with prescaler at 6, stay paused, resume
        wait_en("sync_pause");
        repeat (9) tick();
        for (int t = 1; t <= 60; t++) begin
            btn_start_stop = (t <= 10);
            tick();
            if (t <= 7) chk($sformatf("pre_pause_en.%0d", t), 32'(count_en), 32'(t == 1));
            if (t == 7) chk("pre_pause_state", 32'(state), 32'(S_RUN));
            if (t >= 8) chk($sformatf("paused.%0d", t), 32'({state, count_en, running}), 32'({S_PAUSE, 2'b00}));
        end
        for (int t = 1; t <= 20; t++) begin
            btn_start_stop = (t <= 10);
            tick();
            if (t <= 7) chk($sformatf("resume_wait.%0d", t), 32'(state), 32'(S_PAUSE));
            else chk($sformatf("resume_run.%0d", t), 32'({state, count_en}), 32'({S_RUN, t == 11}));
        end

        // clear ignored in RUN
        for (int t = 1; t <= 20; t++) begin
            btn_clear = (t <= 10);
            tick();
            chk($sformatf("clr_in_run.%0d", t), 32'({state, count_clr}), 32'({S_RUN, 1'b0}));
        end
        for (int t = 1; t <= 20; t++) begin
            btn_start_stop = (t <= 10);
            tick();
            if (t == 8) chk("pause_for_clr", 32'(state), 32'(S_PAUSE));
        end
        for (int t = 1; t <= 20; t++) begin
            logic [2:0] e;
            btn_clear = (t <= 10);
            tick();
            e = (t < 8) ? {S_PAUSE, 1'b0} : (t == 8) ? {S_IDLE, 1'b1} : {S_IDLE, 1'b0};
            chk($sformatf("clr_in_pause.%0d", t), 32'({state, count_clr}), 32'(e));
        end
        // prescaler cleared: first count_en again in the 10th RUN cycle
        for (int t = 1; t <= 25; t++) begin
            btn_start_stop = (t <= 10);
            tick();
            if (t < 8) chk($sformatf("restart_idle.%0d", t), 32'(outs()), 32'(O_IDLE));
            else chk($sformatf("restart_run.%0d", t), 32'({state, count_en}), 32'({S_RUN, t == 17}));
        end

        // coincident clear and start_stop in PAUSE: clear wins
        for (int t = 1; t <= 20; t++) begin
            btn_start_stop = (t <= 10);
            tick();
            if (t == 8) chk("pause_for_both", 32'(state), 32'(S_PAUSE));
        end
        for (int t = 1; t <= 20; t++) begin
            logic [6:0] e;
            btn_start_stop = (t <= 10);
            btn_clear      = (t <= 10);
            tick();
            e = (t < 8) ? 7'b10_00000 : (t == 8) ? 7'b00_01000 : O_IDLE;
            chk($sformatf("both_in_pause.%0d", t), 32'(outs()), 32'(e));
        end

        // async reset in LAP while count_en is high
        for (int t = 1; t <= 20; t++) begin
            btn_start_stop = (t <= 10);
            tick();
            if (t == 8) chk("run_for_reset", 32'(state), 32'(S_RUN));
        end
        for (int t = 1; t <= 20; t++) begin
            btn_lap = (t <= 10);
            tick();
            if (t == 8) chk("lap_for_reset", 32'({state, lap_latch, disp_freeze}), 32'({S_LAP, 2'b11}));
        end
        wait_en("sync_reset");
        #3 reset = 1'b1;
        #1;
        chk("async_reset_outs", 32'(outs()), 32'(O_IDLE));
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            chk($sformatf("post_reset.%0d", t), 32'(outs()), 32'(O_IDLE));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Front-panel sequencer for the MM:SS stopwatch counter.
- Synchronises and debounces three raw push-buttons: start/stop, lap and clear.
- Runs a run/pause/lap state machine.
- Generates the per-second count enable, the counter clear and the display freeze/latch controls that drive the BCD digit counter and display path.
- Single clock domain; replaces direct button-edge clocking of the counter.

Parameters:
TICK_DIV, 50_000_000, clk cycles per count_en pulse (1 Hz at 50 MHz); minimum 2
DEB_CYCLES, 1_000_000, consecutive stable synchronised cycles required to accept a button level change; minimum 1

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
btn_start_stop  in  1  raw button, active-high, asynchronous to clk
btn_lap  in  1  raw button, active-high, asynchronous to clk
btn_clear  in  1  raw button, active-high, asynchronous to clk
count_en  out  1  one-cycle enable; the digit counter advances by one second
count_clr  out  1  one-cycle pulse; the digit counter returns to 00:00
lap_latch  out  1  one-cycle pulse; the display register captures the current digits
disp_freeze  out  1  level; display shows the latched lap value instead of live digits
running  out  1  level; high in RUN or LAP
state  out  2  IDLE=00, RUN=01, PAUSE=10, LAP=11

Behaviour:
- Reset (async assert, sync to clk edge on release): state=IDLE, prescaler=0, sync FFs=0, debounced levels=0, debounce counters=0; all outputs 0.
- Per button input path:
  - 2-FF synchroniser.
  - Debounce counter: increments while the synchronised level differs from the debounced level, and clears when they match.
  - When the counter reaches DEB_CYCLES, the debounced level takes the synchronised value and the counter clears.
  - Press event = 1-cycle pulse in the cycle the debounced level rises 0->1. Release generates no event.
  - A button held through reset release produces one press event after DEB_CYCLES.
- Event priority when presses coincide in the same cycle: clear > start_stop > lap. Only the highest-priority valid event in that cycle acts; the others are dropped.
- FSM transitions take effect at the clk edge after the event cycle:
  - IDLE: start_stop -> RUN. Clear -> stays IDLE, count_clr pulse. Lap ignored.
  - RUN: start_stop -> PAUSE. Lap -> LAP, lap_latch pulse. Clear ignored.
  - LAP: lap -> RUN. Start_stop -> PAUSE. Clear ignored. Counting continues.
  - PAUSE: start_stop -> RUN. Clear -> IDLE, count_clr pulse. Lap ignored.
- Output levels:
  - disp_freeze = 1 exactly while state==LAP.
  - running = (state==RUN or state==LAP).
- count_clr and lap_latch are registered: asserted for exactly one cycle, the same cycle state shows its new value.
- Prescaler (width clog2(TICK_DIV)):
  - Increments every cycle while running, wrapping TICK_DIV-1 -> 0.
  - Holds its value in PAUSE, so resume preserves the partial second.
  - Forced to 0 in IDLE and on count_clr.
- count_en = running AND prescaler==TICK_DIV-1 (combinational from registers, one cycle wide).
  - From prescaler=0, the first count_en is in the TICK_DIV-th running cycle.
  - count_en may coincide with the event cycle of a start_stop press; it is honoured.
- No count_en in IDLE or PAUSE. count_en and count_clr are never high in the same cycle.
- Reset asserted mid-operation: all outputs drop to 0 immediately (async), FSM returns to IDLE, and no pulse is emitted on reset release.

Test Plan:
(Benches use TICK_DIV=10, DEB_CYCLES=4.)
- Reset, then press start_stop for 20 cycles -> press event 7 cycles after the raw edge (2 sync + 4 debounce + 1 edge); state=01 one cycle later; count_en in the 10th and 20th RUN cycles only.
- btn_lap glitches of 1, 2 and 3 cycles separated by 5 low cycles, then a 6-cycle press -> exactly one lap event; lap_latch pulses once; disp_freeze=1; count_en cadence unchanged; second lap press -> disp_freeze=0, state=01.
- Pause with prescaler=6, idle 50 cycles (no count_en), resume -> first count_en in the 4th RUN cycle after resume.
- btn_clear pressed in RUN -> no count_clr, state stays 01. Pause, press clear -> count_clr high exactly 1 cycle, state=00, prescaler=0.
- In PAUSE, btn_clear and btn_start_stop rise in the same cycle -> state=00, count_clr pulse, no transition to RUN.
- Assert reset asynchronously mid-cycle in LAP -> count_en, disp_freeze, running and state go to 0 before the next clk edge; after release, no pulses until a new press.
